// File: rtl/timer_pkg.sv
// Shared constants and types for the 8-bit timer: register addresses, TCR/TSR bit positions
// and the APB responder state encoding.
package timer_pkg;

  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TCNT = 8'h03;

  localparam int unsigned TCR_LOAD   = 7;
  localparam int unsigned TCR_DOWN   = 5;
  localparam int unsigned TCR_EN     = 4;
  localparam int unsigned TCR_CKS_HI = 1;
  localparam int unsigned TCR_CKS_LO = 0;
  // Implemented TCR bits; the rest read as zero.
  localparam logic [7:0]  TCR_MASK   = 8'hB3;

  localparam int unsigned TSR_OVF = 0;
  localparam int unsigned TSR_UDF = 1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StWait
  } apb_state_e;

endpackage

// File: rtl/timer_apb_regs_if.sv
// APB bus bundle between the CPU bus master and the timer register file.
interface timer_apb_regs_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_apb_fsm.sv
// APB handshake FSM for the timer register file. Optional TIMER_APB_WAIT_EN adds one wait
// state so every transfer takes 3 pclk instead of 2.
module timer_apb_fsm
  import timer_pkg::*;
(
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic wr_en,
  output logic rd_en,
  output logic pready
);

  apb_state_e state_q;
  logic       pready_q;

  // A setup phase seen from IDLE/SETUP is the SETUP cycle itself, so ACCESS follows directly.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= StIdle;
      pready_q <= 1'b0;
    end else begin
      pready_q <= 1'b0;
      unique case (state_q)
        StIdle, StSetup: begin
          if (psel && !penable) begin
            state_q <= StAccess;
`ifdef TIMER_APB_WAIT_EN
            pready_q <= 1'b0;
`else
            pready_q <= 1'b1;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
`ifdef TIMER_APB_WAIT_EN
          state_q  <= StWait;
          pready_q <= 1'b1;
`else
          state_q  <= psel ? StSetup : StIdle;
`endif
        end
        StWait:   state_q <= psel ? StSetup : StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign pready = pready_q;
  assign wr_en  = pready_q & psel & penable & pwrite;
  assign rd_en  = pready_q & psel & penable & ~pwrite;

endmodule

// File: rtl/timer_apb_regs.sv
// APB register file for the 8-bit timer: TDR, TCR, sticky TSR flags and a TCNT mirror.
// Define TIMER_APB_WAIT_EN for one wait state per transfer with registered read data.
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                   pclk,
  input  logic                   presetn,
  timer_apb_regs_if.slave        apb,
  input  logic [7:0]             tcnt,
  input  logic                   ovf_pulse,
  input  logic                   udf_pulse,
  output logic [7:0]             tdr,
  output logic                   load,
  output logic                   down,
  output logic                   en,
  output logic [1:0]             cks
);

  logic       wr_en;
  logic       rd_en;
  logic       pready;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       mapped;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;

  timer_apb_fsm u_fsm (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (apb.psel),
    .penable (apb.penable),
    .pwrite  (apb.pwrite),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .pready  (pready)
  );

  assign wdata  = 8'(apb.pwdata);
  assign mapped = (apb.paddr <= ADDR_W'(ADDR_TCNT));

  always_comb begin
    rdata = '0;
    case (apb.paddr)
      ADDR_W'(ADDR_TDR):  rdata = tdr_q;
      ADDR_W'(ADDR_TCR):  rdata = tcr_q;
      ADDR_W'(ADDR_TSR):  rdata = {6'b0, tsr_q};
      ADDR_W'(ADDR_TCNT): rdata = tcnt;
      default:            rdata = '0;
    endcase
  end

  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q;
    tsr_d = tsr_q;
    if (wr_en && apb.paddr == ADDR_W'(ADDR_TDR)) tdr_d = wdata;
    if (wr_en && apb.paddr == ADDR_W'(ADDR_TCR)) tcr_d = wdata & TCR_MASK;
    // Writing 0 clears a flag, writing 1 keeps it; a same-cycle pulse always wins.
    if (wr_en && apb.paddr == ADDR_W'(ADDR_TSR)) tsr_d = tsr_q & wdata[1:0];
    tsr_d[TSR_OVF] = tsr_d[TSR_OVF] | ovf_pulse;
    tsr_d[TSR_UDF] = tsr_d[TSR_UDF] | udf_pulse;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_q <= '0;
      tcr_q <= '0;
      tsr_q <= '0;
    end else begin
      tdr_q <= tdr_d;
      tcr_q <= tcr_d;
      tsr_q <= tsr_d;
    end
  end

`ifdef TIMER_APB_WAIT_EN
  logic [7:0] prdata_q;

  // Capture during the ACCESS cycle so the data is stable in the completing WAIT cycle.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q <= '0;
    end else if (apb.psel && apb.penable && !pready && !apb.pwrite) begin
      prdata_q <= rdata;
    end
  end

  assign apb.prdata = rd_en ? DATA_W'(prdata_q) : '0;
`else
  assign apb.prdata = rd_en ? DATA_W'(rdata) : '0;
`endif

  assign apb.pready  = pready;
  assign apb.pslverr = (wr_en | rd_en) & ~mapped;

  assign tdr  = tdr_q;
  assign load = tcr_q[TCR_LOAD];
  assign down = tcr_q[TCR_DOWN];
  assign en   = tcr_q[TCR_EN];
  assign cks  = tcr_q[TCR_CKS_HI:TCR_CKS_LO];

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed self-checking bench for timer_apb_regs: register map, TSR flag rules, error
// responses, handshake timing and reset behaviour.
module tb_timer_apb_regs;

`ifdef TIMER_APB_WAIT_EN
  localparam int ExpCyc = 3;
`else
  localparam int ExpCyc = 2;
`endif

  logic       pclk;
  logic       presetn;
  logic [7:0] tcnt;
  logic       ovf_pulse;
  logic       udf_pulse;
  logic [7:0] tdr;
  logic       load;
  logic       down;
  logic       en;
  logic [1:0] cks;

  int errors;
  int checks;

  timer_apb_regs_if #(.ADDR_W(8), .DATA_W(8)) apb ();

  timer_apb_regs #(.ADDR_W(8), .DATA_W(8)) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (apb),
    .tcnt      (tcnt),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse),
    .tdr       (tdr),
    .load      (load),
    .down      (down),
    .en        (en),
    .cks       (cks)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Runs one transfer starting just after a rising edge; returns just after the commit edge
  // with penable low and psel still high, so an immediate next call is back-to-back.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                      input logic ovf_at_commit, output logic [7:0] rd, output logic err,
                      output int cyc);
    bit done;
    done = 0;
    rd = '0;
    err = 1'b0;
    cyc = 1;
    apb.psel = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite = wr;
    apb.paddr = addr;
    apb.pwdata = wd;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge pclk);
      cyc++;
      if (apb.pready === 1'b1) begin
        rd = apb.prdata;
        err = apb.pslverr;
        done = 1;
        if (ovf_at_commit) ovf_pulse = 1'b1;
      end
      @(posedge pclk); #1;
      ovf_pulse = 1'b0;
    end
    apb.penable = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=%02h got no pready within 8 cycles", addr);
    end
  endtask

  task automatic idle();
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic err;
    int cyc;
    presetn = 1'b0;
    #2;
    checks++;
    if ({apb.prdata, apb.pready, apb.pslverr} !== 10'b0) begin
      errors++;
      $display("FAIL reset_bus got prdata=%02h pready=%b pslverr=%b want 00/0/0",
               apb.prdata, apb.pready, apb.pslverr);
    end
    checks++;
    if ({tdr, load, down, en, cks} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outs got tdr=%02h load=%b down=%b en=%b cks=%0d want all 0",
               tdr, load, down, en, cks);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    for (int a = 0; a < 4; a++) begin
      xfer(1'b0, 8'(a), 8'h00, 1'b0, rd, err, cyc);
      idle();
      checks++;
      if (rd !== 8'h00 || err !== 1'b0 || cyc != ExpCyc) begin
        errors++;
        $display("FAIL reset_read addr=%0d got %02h err=%b cyc=%0d want 00 err=0 cyc=%0d",
                 a, rd, err, cyc, ExpCyc);
      end
    end
  endtask

  task automatic test_config();
    logic [7:0] rd;
    logic err;
    int cyc;
    xfer(1'b1, 8'h00, 8'hFF, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (tdr !== 8'hFF) begin
      errors++;
      $display("FAIL tdr_write got %02h want ff", tdr);
    end
    xfer(1'b1, 8'h01, 8'h80, 1'b0, rd, err, cyc);
    checks++;
    if (load !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL tcr_load got load=%b en=%b want 1/0", load, en);
    end
    idle();
    xfer(1'b1, 8'h01, 8'h30, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if ({load, down, en, cks} !== 5'b01100) begin
      errors++;
      $display("FAIL tcr_run got load=%b down=%b en=%b cks=%0d want 0/1/1/0",
               load, down, en, cks);
    end
    xfer(1'b0, 8'h01, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h30) begin
      errors++;
      $display("FAIL tcr_read got %02h want 30", rd);
    end
    xfer(1'b1, 8'h01, 8'hFF, 1'b0, rd, err, cyc);
    idle();
    xfer(1'b0, 8'h01, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'hB3 || cks !== 2'd3) begin
      errors++;
      $display("FAIL tcr_mask got %02h cks=%0d want b3 cks=3", rd, cks);
    end
  endtask

  task automatic test_tcnt();
    logic [7:0] rd;
    logic err;
    int cyc;
    tcnt = 8'h5A;
    xfer(1'b1, 8'h03, 8'hC3, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tcnt_write_err got %b want 0", err);
    end
    xfer(1'b0, 8'h03, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h5A) begin
      errors++;
      $display("FAIL tcnt_read got %02h want 5a", rd);
    end
  endtask

  task automatic test_tsr_flags();
    logic [7:0] rd;
    logic err;
    int cyc;
    udf_pulse = 1'b1;
    @(posedge pclk); #1;
    udf_pulse = 1'b0;
    xfer(1'b0, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h02) begin
      errors++;
      $display("FAIL tsr_udf got %02h want 02", rd);
    end
    ovf_pulse = 1'b1;
    @(posedge pclk); #1;
    ovf_pulse = 1'b0;
    xfer(1'b0, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h03) begin
      errors++;
      $display("FAIL tsr_both got %02h want 03", rd);
    end
    xfer(1'b1, 8'h02, 8'h01, 1'b0, rd, err, cyc);
    idle();
    xfer(1'b0, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL tsr_clr_udf got %02h want 01", rd);
    end
    xfer(1'b1, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
    xfer(1'b0, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL tsr_clr_all got %02h want 00", rd);
    end
  endtask

  task automatic test_tsr_collision();
    logic [7:0] rd;
    logic err;
    int cyc;
    udf_pulse = 1'b1;
    @(posedge pclk); #1;
    udf_pulse = 1'b0;
    xfer(1'b1, 8'h02, 8'h00, 1'b1, rd, err, cyc);
    idle();
    xfer(1'b0, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL tsr_set_wins got %02h want 01", rd);
    end
    xfer(1'b1, 8'h02, 8'h00, 1'b0, rd, err, cyc);
    idle();
  endtask

  task automatic test_unmapped();
    logic [7:0] rd;
    logic err;
    int cyc;
    xfer(1'b1, 8'h07, 8'h55, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (err !== 1'b1 || tdr !== 8'hFF || {load, down, en, cks} !== 5'b11111) begin
      errors++;
      $display("FAIL unmapped_write got err=%b tdr=%02h tcr_outs=%b want 1/ff/11111",
               err, tdr, {load, down, en, cks});
    end
    xfer(1'b0, 8'h07, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h00 || err !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_read got %02h err=%b want 00 err=1", rd, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic err;
    int cyc;
    xfer(1'b1, 8'h00, 8'h12, 1'b0, rd, err, cyc);
    xfer(1'b0, 8'h00, 8'h00, 1'b0, rd, err, cyc);
    checks++;
    if (rd !== 8'h12 || cyc != ExpCyc) begin
      errors++;
      $display("FAIL b2b_tdr got %02h cyc=%0d want 12 cyc=%0d", rd, cyc, ExpCyc);
    end
    xfer(1'b0, 8'h01, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'hB3 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tcr got %02h err=%b want b3 err=0", rd, err);
    end
  endtask

  task automatic test_orphan_penable();
    bit seen;
    seen = 0;
    apb.psel = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite = 1'b1;
    apb.paddr = 8'h00;
    apb.pwdata = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      if (apb.pready !== 1'b0) seen = 1;
    end
    @(posedge pclk); #1;
    idle();
    checks++;
    if (seen || tdr !== 8'h12) begin
      errors++;
      $display("FAIL orphan_penable got pready_seen=%0d tdr=%02h want 0/12", seen, tdr);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] rd;
    logic err;
    int cyc;
    apb.psel = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite = 1'b1;
    apb.paddr = 8'h00;
    apb.pwdata = 8'hAA;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    #1;
    presetn = 1'b0;
    #1;
    checks++;
    if (apb.pready !== 1'b0 || tdr !== 8'h00 || load !== 1'b0 || cks !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid got pready=%b tdr=%02h load=%b cks=%0d want 0/00/0/0",
               apb.pready, tdr, load, cks);
    end
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 8'h00, 8'h00, 1'b0, rd, err, cyc);
    idle();
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_abandon got tdr=%02h want 00", rd);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    tcnt = 8'h00;
    ovf_pulse = 1'b0;
    udf_pulse = 1'b0;
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
    apb.paddr = '0;
    apb.pwdata = '0;
    presetn = 1'b0;
    test_reset();
    test_config();
    test_tcnt();
    test_tsr_flags();
    test_tsr_collision();
    test_unmapped();
    test_back_to_back();
    test_orphan_penable();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_apb_regs.md
# timer_apb_regs

APB responder and register file for the 8-bit timer. Completes the APB transfers issued by the CPU bus master and holds the TDR, TCR and TSR registers. Drives configuration to the counter core, and latches the core's overflow/underflow pulses into sticky status flags. It sits between the APB bus and the counter datapath inside the timer top.

## Interface
- `ADDR_W`, 8: APB address width
- `DATA_W`, 8: APB data width; all registers are 8 bits
- `pclk`  in  1  APB clock; the only clock
- `presetn`  in  1  asynchronous, active-low reset
- `psel`  in  1  slave select
- `penable`  in  1  access phase
- `pwrite`  in  1  1 = write, 0 = read
- `paddr`  in  ADDR_W  register address
- `pwdata`  in  DATA_W  write data
- `prdata`  out  DATA_W  read data
- `pready`  out  1  transfer complete
- `pslverr`  out  1  error response for an unmapped address
- `tcnt`  in  8  live counter value from the core
- `ovf_pulse`  in  1  one-pclk overflow event (count up, 0xFF to 0x00)
- `udf_pulse`  in  1  one-pclk underflow event (count down, 0x00 to 0xFF)
- `tdr`  out  8  reload value
- `load`  out  1  TCR[7]; level, core loads `tdr` into its counter while high
- `down`  out  1  TCR[5]; 1 = count down
- `en`  out  1  TCR[4]; count enable
- `cks`  out  2  TCR[1:0]; clk_in divider select (÷2/÷4/÷8/÷16)

## Operation
- Register map:
  - 0x00 TDR: RW, reset 0x00.
  - 0x01 TCR: RW on bits 7, 5, 4, 1:0. Other bits read 0. Reset 0x00.
  - 0x02 TSR: bit0 OVF, bit1 UDF. Other bits read 0. Reset 0x00.
  - 0x03 TCNT: read-only mirror of `tcnt`. Writes are accepted with OKAY and ignored.
- Any other address: write discarded, `prdata` = 0x00, `pslverr` = 1 in the completing cycle.
- TSR flags:
  - A pulse sets its flag; the flag stays set until cleared.
  - Writing 0 to a flag bit clears it. Writing 1 has no effect.
  - If a set pulse and a clearing write occur in the same cycle, the set wins and the flag reads 1.
- Example sequence: write TCR=0x80 (load asserted), then TCR=0x30 (load released, down, enabled). Writing TCR=0x00 pauses counting with the count held in the core.
- APB FSM states:
  - IDLE: go to SETUP when `psel` && !`penable`.
  - SETUP: go to ACCESS next cycle.
  - ACCESS: complete when `pready`=1, then go to SETUP if `psel` is still high, else IDLE.
  - WAIT: exists only with the macro (see Configuration).
- `penable` high without a preceding SETUP is ignored: no register effect and `pready` stays 0.

## Timing
- Reset values: `prdata` 0x00, `pready` 0, `pslverr` 0, `tdr` 0x00, `load`/`down`/`en` 0, `cks` 0, FSM in IDLE.
- Write commit: on the rising edge where `psel`&`penable`&`pready`. The new value is visible on the outputs the following cycle.
- Read data: `prdata` is valid combinationally during the completing ACCESS cycle. It is 0x00 at all other times.
- `pready`/`pslverr` are asserted only in the completing ACCESS cycle. Zero wait states by default, so each transfer takes 2 pclk.
- A flag set by a pulse in cycle N reads as 1 for a TSR read completing in cycle N+1 or later.
- Reset asserted mid-transfer: everything goes to reset values immediately and the transfer is abandoned.

## Configuration
- `TIMER_APB_WAIT_EN` defined:
  - The FSM inserts one WAIT cycle: ACCESS with `pready`=0, then WAIT with `pready`=1.
  - Every transfer takes 3 pclk. `prdata` is registered at the end of ACCESS.
  - The commit happens on the WAIT edge.
- Undefined: no WAIT state; `pready`=1 in the first ACCESS cycle.

## Structure
- The shared package `timer_pkg` holds:
  - address constants `ADDR_TDR`/`ADDR_TCR`/`ADDR_TSR`/`ADDR_TCNT`
  - TCR bit indices (`TCR_LOAD`=7, `TCR_DOWN`=5, `TCR_EN`=4, `TCR_CKS`=1:0)
  - TSR bit indices (`TSR_OVF`=0, `TSR_UDF`=1)
  - the APB state enum
- One sub-module, `timer_apb_fsm`: APB handshake FSM. It outputs `wr_en`, `rd_en`, `pready`. The register file stays in `timer_apb_regs`.

## Test plan
- Reset, then read 0x00–0x03 -> all 0x00, `pslverr`=0, 2 pclk per transfer (3 with `TIMER_APB_WAIT_EN`).
- Write TDR=0xFF, TCR=0x80, TCR=0x30 -> `tdr`=0xFF; `load`=1 after the second write; after the third, `load`=0, `down`=1, `en`=1; TCR reads 0x30.
- Write TCR=0xFF -> TCR reads 0xB3.
- Pulse `udf_pulse` -> TSR reads 0x02. Pulse `ovf_pulse` -> TSR reads 0x03. Write TSR=0x01 -> reads 0x01. Write 0x00 -> reads 0x00.
- TSR=0x00 write in the same cycle as `ovf_pulse` -> TSR reads 0x01.
- Write 0x55 to address 0x07 -> `pslverr`=1, no register changes. Read 0x07 -> `prdata`=0x00, `pslverr`=1.
